apb2lb_tmo: RTL

APB2LB_TMO -- requirements
Module: apb2lb_tmo

---
 rtl/apb2lb_pkg.sv | 19 +
 rtl/apb2lb_tmo_cnt.sv | 36 +++
 rtl/apb2lb_tmo.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/apb2lb_pkg.sv
// apb2lb_pkg -- shared definitions for the APB to local-bus bridge.
//   state_e      : bridge FSM state encoding (also exported for debug)
//   *_DEF        : default ADDR_W / DATA_W / TIMEOUT values
//   CNT_W        : timeout counter width (covers TIMEOUT up to 65535)
package apb2lb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam int ADDR_W_DEF  = 16;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 255;
    localparam int CNT_W       = 16;

endpackage

// File: rtl/apb2lb_tmo_cnt.sv
// apb2lb_tmo_cnt -- wait-cycle counter for the bridge timeout.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : zero the count (new transfer accepted)
//   enable     : one wait cycle elapses this clock
//   expired    : this enabled cycle is the TIMEOUT-th wait cycle
module apb2lb_tmo_cnt
    import apb2lb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // The count after this cycle's increment would equal TIMEOUT.
    assign expired = enable && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/apb2lb_tmo.sv
// apb2lb_tmo -- APB slave to simple local-bus bridge with optional timeout.
// Optional feature: define APB2LB_TIMEOUT_EN to build the wait-cycle timeout
// (pslverr on expiry). Without it WR/RD wait forever and pslverr stays 0.
// Ports:
//   pclk, presetn                       : clock, sync active-low reset
//   psel, penable, pwrite, paddr,
//   pwdata, pstrb                       : APB request
//   prdata, pready, pslverr             : APB response (registered)
//   waddr, wdata, wstrb, wen, wready    : local write (wen held until wready)
//   raddr, ren, rdata, rvalid           : local read (ren single pulse)
//   fsm_state                           : current FSM state (debug)
// Local-bus handshake: a write completes on the edge where wen=1 and
// wready=1; a read completes on the first edge in RD with rvalid=1,
// including the edge that ends the ren pulse cycle.
module apb2lb_tmo
    import apb2lb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int STRB_W  = DATA_W / 8,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    input  logic [STRB_W-1:0] pstrb,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic              wready,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wen,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rvalid,
    output logic [ADDR_W-1:0] raddr,
    output logic              ren,
    output state_e            fsm_state
);

    state_e            state, state_n;
    logic [DATA_W-1:0] prdata_n, wdata_n;
    logic [ADDR_W-1:0] waddr_n, raddr_n;
    logic [STRB_W-1:0] wstrb_n;
    logic              pready_n, pslverr_n, wen_n, ren_n;
    logic              cnt_clear, cnt_en, expired;

    assign fsm_state = state;

`ifdef APB2LB_TIMEOUT_EN
    apb2lb_tmo_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_cnt (
        .clk    (pclk),
        .rst_n  (presetn),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .expired(expired)
    );
`else
    assign expired = 1'b0;
    logic unused_cnt;
    assign unused_cnt = cnt_clear ^ cnt_en ^ (TIMEOUT == 0);
`endif

    always_comb begin
        state_n   = state;
        prdata_n  = prdata;
        waddr_n   = waddr;
        raddr_n   = raddr;
        wdata_n   = wdata;
        wstrb_n   = wstrb;
        pready_n  = 1'b0;
        pslverr_n = 1'b0;
        wen_n     = 1'b0;
        ren_n     = 1'b0;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (psel && !penable) begin
                    waddr_n   = paddr;
                    raddr_n   = paddr;
                    wdata_n   = pwdata;
                    wstrb_n   = pstrb;
                    cnt_clear = 1'b1;
                    state_n   = pwrite ? ST_WR : ST_RD;
                    wen_n     = pwrite;
                    ren_n     = !pwrite;
                end
            end
            ST_WR: begin
                cnt_en = 1'b1;
                if (wready || expired) begin
                    // A handshake on the expiry cycle still counts as success.
                    state_n   = ST_RESP;
                    pready_n  = 1'b1;
                    pslverr_n = !wready;
                    prdata_n  = '0;
                end else begin
                    wen_n = 1'b1;
                end
            end
            ST_RD: begin
                cnt_en = 1'b1;
                if (rvalid) begin
                    state_n  = ST_RESP;
                    pready_n = 1'b1;
                    prdata_n = rdata;
                end else if (expired) begin
                    state_n   = ST_RESP;
                    pready_n  = 1'b1;
                    pslverr_n = 1'b1;
                    prdata_n  = '0;
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state   <= ST_IDLE;
            prdata  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            waddr   <= '0;
            raddr   <= '0;
            wdata   <= '0;
            wstrb   <= '0;
            wen     <= 1'b0;
            ren     <= 1'b0;
        end else begin
            state   <= state_n;
            prdata  <= prdata_n;
            pready  <= pready_n;
            pslverr <= pslverr_n;
            waddr   <= waddr_n;
            raddr   <= raddr_n;
            wdata   <= wdata_n;
            wstrb   <= wstrb_n;
            wen     <= wen_n;
            ren     <= ren_n;
        end
    end

endmodule
